// File: rtl/pipe_arb_pkg.sv
// -----------------------------------------------------------------------------
// pipe_arb_pkg
// Shared definitions for the pipeline-stage arbiter:
//   - arb_state_e : ownership FSM encoding (ARB_IDLE / ARB_LOCKED)
//   - CNT_W       : burst counter width (holds BURST values up to 15)
//   - idx_width() : width of a requester index, never narrower than 1 bit
// -----------------------------------------------------------------------------
package pipe_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned CNT_W = 4;

    // clog2-style index width, clamped to 1 so a single-entry index still exists
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_stage_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin scan: finds the first set bit of req starting at
// (last+1) mod NUM_REQ and wrapping upward.
// Ports:
//   req   in  NUM_REQ  candidate request vector
//   last  in  IDX_W    index granted most recently (scan starts just past it)
//   sel   out IDX_W    chosen index (0 when nothing is requesting)
//   found out 1        at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
    import pipe_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   sel,
    output logic               found
);

    // Scan from the farthest offset down to the nearest one so the entry
    // closest to last+1 is written last and therefore wins.
    always_comb begin
        int unsigned idx_v;
        sel   = '0;
        found = |req;
        idx_v = 32'd0;
        for (int unsigned k = NUM_REQ; k >= 32'd1; k--) begin
            idx_v = (32'(last) + k) % NUM_REQ;
            sel   = req[idx_v] ? IDX_W'(idx_v) : sel;
        end
    end

endmodule

// File: rtl/pipe_stage_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_stage_arbiter
// Shares one registered output stage between NUM_REQ valid/ready requesters.
// Selection is round-robin, but a requester that wins keeps ownership for up
// to BURST consecutive transfers while it keeps its valid asserted. The
// granted word lands in a one-entry buffer that refills in the same cycle the
// downstream consumer drains it.
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous active-high reset
//   req_valid  in   NUM_REQ        per-requester word valid
//   req_data   in   NUM_REQ*WIDTH  packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  out  NUM_REQ        per-requester accept, one-hot or zero
//   out_data   out  WIDTH          buffered word
//   out_src    out  IDX_W          requester that supplied out_data
//   out_valid  out  1              buffer holds a word
//   out_ready  in   1              downstream takes the buffered word
// -----------------------------------------------------------------------------
module pipe_stage_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned BURST   = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [IDX_W-1:0]           out_src,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 32'd1);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [IDX_W-1:0]  owner_r;
    logic [IDX_W-1:0]  owner_nxt_s;
    logic [CNT_W-1:0]  burst_cnt_r;
    logic [CNT_W-1:0]  burst_cnt_nxt_s;
    logic [IDX_W-1:0]  last_r;

    logic              load_en_s;
    logic              owner_hold_s;
    logic [IDX_W-1:0]  pick_sel_s;
    logic              pick_found_s;
    logic [IDX_W-1:0]  sel_s;
    logic              sel_found_s;
    logic              xfer_s;
    logic [WIDTH-1:0]  sel_word_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (last_r),
        .sel   (pick_sel_s),
        .found (pick_found_s)
    );

    // Grant qualification: the owner keeps the stage while valid and within
    // budget; otherwise the round-robin pick applies. Reset blocks all grants.
    always_comb begin
        load_en_s    = ~out_valid | out_ready;
        owner_hold_s = (state_r == ARB_LOCKED) & req_valid[owner_r] & (burst_cnt_r < BURST_C);
        if (owner_hold_s) begin
            sel_s       = owner_r;
            sel_found_s = 1'b1;
        end else begin
            sel_s       = pick_sel_s;
            sel_found_s = pick_found_s;
        end
        xfer_s = ~rst & load_en_s & sel_found_s;
    end

    // One-hot ready; sel always points at a valid requester when found, so a
    // ready bit implies a transfer.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = xfer_s & (sel_s == IDX_W'(i));
        end
    end

    // Data mux for the selected requester; only the buffer sees req_data.
    always_comb begin
        sel_word_s = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel_word_s = (sel_s == IDX_W'(i)) ? req_data[i*WIDTH +: WIDTH] : sel_word_s;
        end
    end

    // Ownership FSM next-state; stalls (load_en low) freeze owner and budget.
    always_comb begin
        state_nxt_s     = state_r;
        owner_nxt_s     = owner_r;
        burst_cnt_nxt_s = burst_cnt_r;
        case (state_r)
            ARB_IDLE: begin
                if (xfer_s && (BURST != 32'd1)) begin
                    state_nxt_s     = ARB_LOCKED;
                    owner_nxt_s     = sel_s;
                    burst_cnt_nxt_s = CNT_ONE;
                end else begin
                    state_nxt_s     = ARB_IDLE;
                    burst_cnt_nxt_s = '0;
                end
            end
            ARB_LOCKED: begin
                if (!load_en_s) begin
                    state_nxt_s = ARB_LOCKED;
                end else if (xfer_s && owner_hold_s) begin
                    // last already equals the owner, so rotation after the
                    // budget runs out starts past it automatically
                    if ((burst_cnt_r + CNT_ONE) == BURST_C) begin
                        state_nxt_s     = ARB_IDLE;
                        burst_cnt_nxt_s = '0;
                    end else begin
                        burst_cnt_nxt_s = burst_cnt_r + CNT_ONE;
                    end
                end else if (xfer_s) begin
                    // owner dropped valid: same-cycle handover to the pick
                    if (BURST == 32'd1) begin
                        state_nxt_s     = ARB_IDLE;
                        burst_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s     = ARB_LOCKED;
                        owner_nxt_s     = sel_s;
                        burst_cnt_nxt_s = CNT_ONE;
                    end
                end else begin
                    state_nxt_s     = ARB_IDLE;
                    burst_cnt_nxt_s = '0;
                end
            end
            default: begin
                state_nxt_s     = ARB_IDLE;
                owner_nxt_s     = '0;
                burst_cnt_nxt_s = '0;
            end
        endcase
    end

    // FSM, ownership and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ARB_IDLE;
            owner_r     <= '0;
            burst_cnt_r <= '0;
            last_r      <= LAST_RST;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
            if (xfer_s) begin
                last_r <= sel_s;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // One-entry output buffer; a drained buffer with no new word just clears
    // valid and leaves data/src as they were.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else if (xfer_s) begin
            out_data  <= sel_word_s;
            out_src   <= sel_s;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_pipe_stage_arbiter.sv
module tb_pipe_stage_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int BURST   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] word [4];
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign req_data = {word[3], word[2], word[1], word[0]};

    pipe_stage_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .BURST   (BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
    endtask

    // one transfer cycle: check ready before the edge, buffer after it
    task automatic xfer_cycle(input string tag, input int src);
        logic [3:0] onehot;
        onehot = 4'b0001 << src;
        settle();
        check({tag, "_ready"}, req_ready, onehot);
        edge_step();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_src"}, out_src, src);
        check({tag, "_data"}, out_data, word[src]);
    endtask

    initial begin
        int exp_src;
        rst       = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        word[0]   = 16'h1111;
        word[1]   = 16'h2222;
        word[2]   = 16'h3333;
        word[3]   = 16'h4444;

        // 1: reset with everything valid
        settle();
        check("rst_ready", req_ready, 0);
        edge_step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_src", out_src, 0);
        rst = 1'b0;
        settle();
        check("post_rst_valid", out_valid, 0);

        // 1+2: all valid, bursts of 4 rotating from requester 0
        for (int k = 0; k < 17; k++) begin
            exp_src = (k / 4) % 4;
            xfer_cycle("rr_burst", exp_src);
        end

        // 3: only requester 2, forced rotation re-selects it without a bubble
        do_reset();
        req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            xfer_cycle("solo2", 2);
        end

        // 4: owner 1 drops after two words, requester 3 takes over same cycle
        do_reset();
        req_valid = 4'b0010;
        xfer_cycle("own1_a", 1);
        xfer_cycle("own1_b", 1);
        req_valid = 4'b1000;
        xfer_cycle("handover3", 3);
        req_valid = 4'b1001;
        xfer_cycle("new3_b", 3);
        xfer_cycle("new3_c", 3);
        xfer_cycle("new3_d", 3);
        xfer_cycle("after3", 0);

        // 5: stall with A5A5 buffered, budget must survive the stall
        do_reset();
        word[0]   = 16'hA5A5;
        req_valid = 4'b0001;
        xfer_cycle("stall_load", 0);
        word[0]   = 16'h5A5A;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("stall_ready", req_ready, 0);
            edge_step();
            check("stall_data", out_data, 16'hA5A5);
            check("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        req_valid = 4'b0011;
        xfer_cycle("refill", 0);
        xfer_cycle("budget_3", 0);
        xfer_cycle("budget_4", 0);
        xfer_cycle("rotate1", 1);
        word[0] = 16'h1111;

        // 6: reset during a locked stall discards the buffered word
        do_reset();
        req_valid = 4'b0100;
        xfer_cycle("lock2", 2);
        out_ready = 1'b0;
        edge_step();
        check("lock2_stall_valid", out_valid, 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'hF;
        settle();
        check("midrst_ready", req_ready, 0);
        edge_step();
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_src", out_src, 0);
        rst = 1'b0;
        xfer_cycle("post_midrst", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
